// File: rtl/pedge_8.sv
// Per-bit rising-edge detector: pedge[i] pulses for one cycle after in[i]
// is first sampled high following a low sample. Output is fully registered.
module pedge_8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] pedge,
    input  logic             rst
);

    logic [WIDTH-1:0] prev;

    // prev tracks in even during reset, so a bit already high at release
    // is treated as "seen" and cannot produce a spurious pulse.
    always_ff @(posedge clk) begin
        prev <= in;
        if (rst) begin
            pedge <= '0;
        end else begin
            pedge <= in & ~prev;
        end
    end

endmodule

// File: tb/tb_pedge_8.sv
// Self-checking bench for pedge_8: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a run-length model.
module tb_pedge_8;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] pedge;

    int total;
    int bad;

    pedge_8 #(.WIDTH(W)) dut (
        .clk  (clk),
        .in   (din),
        .pedge(pedge),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] in;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs [NVEC];

    // Reference model: per-bit count of consecutive high samples (saturating).
    // A pulse is due exactly when a bit's run of ones has length one.
    int unsigned run [W];

    task automatic model_step(input logic r, input logic [W-1:0] v,
                              output logic [W-1:0] e);
        e = '0;
        for (int i = 0; i < W; i++) begin
            if (r) begin
                run[i] = v[i] ? 2 : 0;
            end else if (v[i]) begin
                run[i] = (run[i] == 0) ? 1 : 2;
                e[i] = (run[i] == 1);
            end else begin
                run[i] = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got pedge=0x%02h expected 0x%02h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] v);
        rst = r;
        din = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] e;
        int pulses;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din   = '0;

        vecs = '{
            // basic rising edge and an added bit
            '{1'b1, 8'h00, 8'h00}, '{1'b0, 8'h00, 8'h00}, '{1'b0, 8'h90, 8'h90},
            '{1'b0, 8'h90, 8'h00}, '{1'b0, 8'h94, 8'h04}, '{1'b0, 8'h94, 8'h00},
            // simultaneous rises, then falling edges only
            '{1'b0, 8'hFF, 8'h6B}, '{1'b0, 8'hFF, 8'h00}, '{1'b0, 8'h00, 8'h00},
            '{1'b0, 8'h00, 8'h00},
            // reset with input already high
            '{1'b1, 8'hFF, 8'h00}, '{1'b0, 8'hFF, 8'h00}, '{1'b0, 8'hFF, 8'h00},
            '{1'b0, 8'h00, 8'h00}, '{1'b0, 8'h01, 8'h01}, '{1'b0, 8'h01, 8'h00},
            // toggling 0x55/0xAA
            '{1'b0, 8'h55, 8'h54}, '{1'b0, 8'hAA, 8'hAA}, '{1'b0, 8'h55, 8'h55},
            '{1'b0, 8'hAA, 8'hAA}, '{1'b0, 8'h55, 8'h55},
            // reset mid-pulse
            '{1'b0, 8'h00, 8'h00}, '{1'b0, 8'h90, 8'h90}, '{1'b1, 8'h90, 8'h00},
            '{1'b0, 8'h90, 8'h00}, '{1'b0, 8'h90, 8'h00},
            // reset wins over a rising edge, detection resumes afterwards
            '{1'b0, 8'h00, 8'h00}, '{1'b1, 8'h0F, 8'h00}, '{1'b0, 8'h0F, 8'h00},
            '{1'b0, 8'h3F, 8'h30}, '{1'b1, 8'h00, 8'h00}, '{1'b0, 8'h80, 8'h80},
            '{1'b0, 8'h00, 8'h00}, '{1'b0, 8'h80, 8'h80}
        };

        for (int k = 0; k < NVEC; k++) begin
            step(vecs[k].rst, vecs[k].in);
            check($sformatf("vec%0d", k), pedge, vecs[k].exp);
        end

        // Bit held high for many samples: exactly one pulse, on the first sample.
        step(1'b0, 8'h00);
        step(1'b0, 8'h08);
        check("held_first", pedge, 8'h08);
        pulses = 1;
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 8'h08);
            if (pedge[3]) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL held_count: got %0d pulses expected 1", pulses);
        end

        // Single-bit 0/1 toggling: a pulse on every other cycle, none dropped.
        step(1'b0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, (k % 2 == 0) ? 8'h02 : 8'h00);
            check($sformatf("toggle%0d", k), pedge, (k % 2 == 0) ? 8'h02 : 8'h00);
        end

        // Randomized stimulus against the model, starting from a reset.
        step(1'b1, 8'h00);
        model_step(1'b1, 8'h00, e);
        for (int k = 0; k < 400; k++) begin
            logic         r;
            logic [W-1:0] v;
            r = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) == 0) ? din : W'($urandom);
            model_step(r, v, e);
            step(r, v);
            check($sformatf("rand%0d", k), pedge, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
